// File: rtl/mod_74x165_tx.sv
// Parallel-in/serial-out frame transmitter modelled on the 74x165 PISO register,
// with a START/BUSY/DONE frame controller that shifts one word out MSB first.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for START; shift_reg holds (QH shows its MSB)
// ST_SHIFT | shifting SER into bit 0 once per edge; BUSY=1
// ST_DONE  | single-cycle completion strobe; START here reloads immediately

module mod_74x165_tx #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             START,
    input  logic [WIDTH-1:0] D,
    input  logic             SER,
    input  logic             CLK_INH,
    output logic             QH,
    output logic             QH_N,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    count;
    logic             busy_r;
    logic             done_r;

    // Reset takes priority over clock inhibit; inhibit freezes every register.
    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            state     <= ST_IDLE;
            shift_reg <= '0;
            count     <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else if (!CLK_INH) begin
            case (state)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (START) begin
                        shift_reg <= D;
                        count     <= '0;
                        busy_r    <= 1'b1;
                        state     <= ST_SHIFT;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end

                ST_SHIFT: begin
                    shift_reg <= {shift_reg[WIDTH-2:0], SER};
                    if (count == LAST) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        count  <= count + CW'(1);
                        busy_r <= 1'b1;
                        done_r <= 1'b0;
                    end
                end

                ST_DONE: begin
                    done_r <= 1'b0;
                    if (START) begin
                        shift_reg <= D;
                        count     <= '0;
                        busy_r    <= 1'b1;
                        state     <= ST_SHIFT;
                    end else begin
                        busy_r <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end

                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    count  <= '0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // QH and QH_N decode the same flop, so they are complementary in every cycle.
    assign QH   = shift_reg[WIDTH-1];
    assign QH_N = ~shift_reg[WIDTH-1];
    assign BUSY = busy_r;
    assign DONE = done_r;

endmodule
